// File: rtl/ascon_permutation_engine.sv
// Self-sequencing Ascon permutation (p^a / p^b) with a start/done handshake, UNROLL rounds per clock.
// Optional build macro: ASCON_PERM_ABORT_EN adds abort_i to cancel a run in progress.

module constant_addition (
  input  logic [319:0] state_i,
  input  logic [3:0]   idx_i,
  output logic [319:0] state_o
);
  always_comb begin
    state_o = state_i;
    state_o[135:128] = state_i[135:128] ^ {~idx_i, idx_i};
  end
endmodule

module substitution_layer (
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  always_comb begin
    {x0, x1, x2, x3, x4} = state_i;
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    state_o = {x0, x1, x2, x3, x4};
  end
endmodule

module diffusion (
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;

  always_comb begin
    {x0, x1, x2, x3, x4} = state_i;
    state_o = {x0 ^ ror(x0, 19) ^ ror(x0, 28),
               x1 ^ ror(x1, 61) ^ ror(x1, 39),
               x2 ^ ror(x2, 1)  ^ ror(x2, 6),
               x3 ^ ror(x3, 10) ^ ror(x3, 17),
               x4 ^ ror(x4, 7)  ^ ror(x4, 41)};
  end
endmodule

module ascon_round (
  input  logic [319:0] state_i,
  input  logic [3:0]   idx_i,
  output logic [319:0] state_o
);
  logic [319:0] ca_out, sl_out;

  constant_addition  u_ca (.state_i(state_i), .idx_i(idx_i), .state_o(ca_out));
  substitution_layer u_sl (.state_i(ca_out), .state_o(sl_out));
  diffusion          u_dl (.state_i(sl_out), .state_o(state_o));
endmodule

module ascon_permutation_engine #(
  parameter int UNROLL = 1,
  parameter int MAX_NR = 12
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic [3:0]   nr_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam logic [3:0] UNR  = 4'(UNROLL);
  localparam logic [3:0] NMAX = 4'(MAX_NR);

  generate
    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
      $error("ascon_permutation_engine: UNROLL must be 1 or 2");
    end
    if (MAX_NR < 0 || MAX_NR > 12) begin : g_bad_max_nr
      $error("ascon_permutation_engine: MAX_NR must be within 0..12");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    RUN
  } fsm_t;

  fsm_t         fsm_q;
  logic [3:0]   rnd_q;
  logic [319:0] state_q;
  logic         busy_q, done_q;

  logic [3:0]   n_clamp, base_idx, remaining, steps, rnd_next;
  logic [319:0] dp_in, dp_out, r0_out, r1_out;

  // IDLE feeds the fresh input at index 12-n; RUN feeds back the registered state at rnd_q.
  always_comb begin
    n_clamp = (nr_i > NMAX) ? NMAX : nr_i;
    if (fsm_q == IDLE) begin
      dp_in     = state_i;
      base_idx  = 4'd12 - n_clamp;
      remaining = n_clamp;
    end else begin
      dp_in     = state_q;
      base_idx  = rnd_q;
      remaining = 4'd12 - rnd_q;
    end
    steps    = (remaining < UNR) ? remaining : UNR;
    rnd_next = base_idx + steps;
  end

  ascon_round u_round0 (.state_i(dp_in), .idx_i(base_idx), .state_o(r0_out));

  generate
    if (UNROLL == 2) begin : g_unroll2
      ascon_round u_round1 (.state_i(r0_out), .idx_i(base_idx + 4'd1), .state_o(r1_out));
    end else begin : g_unroll1
      assign r1_out = r0_out;
    end
  endgenerate

  // An odd final step bypasses the second stage; a zero-round request passes the input through.
  always_comb begin
    if (steps == 4'd0)      dp_out = dp_in;
    else if (steps == 4'd1) dp_out = r0_out;
    else                    dp_out = r1_out;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= dp_out;
            rnd_q   <= rnd_next;
            if (rnd_next == 4'd12) begin
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              fsm_q  <= RUN;
            end
          end
        end
        RUN: begin
`ifdef ASCON_PERM_ABORT_EN
          if (abort_i) begin
            busy_q <= 1'b0;
            fsm_q  <= IDLE;
          end else
`endif
          begin
            state_q <= dp_out;
            rnd_q   <= rnd_next;
            if (rnd_next == 4'd12) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              fsm_q  <= IDLE;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: UNROLL=1 and UNROLL=2 instances against a column-wise S-box reference model.
// Abort scenario is compiled in when ASCON_PERM_ABORT_EN is defined.

module tb_ascon_permutation_engine;
  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         start1 = 1'b0, start2 = 1'b0;
  logic [3:0]   nr1 = '0, nr2 = '0;
  logic [319:0] sin1 = '0, sin2 = '0;
  logic [319:0] sout1, sout2;
  logic         busy1, busy2, done1, done2;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort1 = 1'b0, abort2 = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ascon_permutation_engine #(.UNROLL(1), .MAX_NR(12)) u_dut1 (
    .clock_i(clk), .resetb_i(rstb), .start_i(start1),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort1),
`endif
    .nr_i(nr1), .state_i(sin1), .state_o(sout1), .busy_o(busy1), .done_o(done1));

  ascon_permutation_engine #(.UNROLL(2), .MAX_NR(12)) u_dut2 (
    .clock_i(clk), .resetb_i(rstb), .start_i(start2),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i(abort2),
`endif
    .nr_i(nr2), .state_i(sin2), .state_o(sout2), .busy_o(busy2), .done_o(done2));

  // Reference model: Ascon S-box as a lookup table applied column by column.
  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ref_rounds(input logic [319:0] s, input int first, input int count);
    logic [63:0] x [5];
    logic [4:0]  v;
    for (int l = 0; l < 5; l++) x[l] = s[319 - 64*l -: 64];
    for (int r = 0; r < count; r++) begin
      int idx;
      idx = first + r;
      x[2] = x[2] ^ 64'(240 - 16*idx + idx);
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        v = SBOX[v];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    return ref_rounds(s, 12 - n, n);
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom)};
    return r;
  endfunction

  task automatic drive(input int d, input logic s, input logic [3:0] n, input logic [319:0] st);
    if (d == 1) begin start1 = s; nr1 = n; sin1 = st; end
    else        begin start2 = s; nr2 = n; sin2 = st; end
  endtask

  task automatic peek(input int d, output logic dn, output logic bz, output logic [319:0] so);
    if (d == 1) begin dn = done1; bz = busy1; so = sout1; end
    else        begin dn = done2; bz = busy2; so = sout2; end
  endtask

  // Starts a run at the current point (just after an edge) and waits, bounded, for done_o.
  task automatic run(input int d, input logic [3:0] n, input logic [319:0] st,
                     output int lat, output int busy_edges, output logic busy_at_done,
                     output logic [319:0] res);
    logic dn, bz;
    logic [319:0] so;
    drive(d, 1'b1, n, st);
    lat = 0; busy_edges = 0; dn = 1'b0; bz = 1'b0; so = '0;
    while (!dn && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) drive(d, 1'b0, 4'd0, '0);
      peek(d, dn, bz, so);
      if (!dn && bz) busy_edges++;
    end
    if (!dn) lat = -1;
    busy_at_done = bz;
    res = so;
  endtask

  task automatic test_reset();
    int seen;
    vectors++; if (sout1 !== '0) begin miscompares++; $display("FAIL reset_state1: got %0h want 0", sout1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL reset_done1: got %b want 0", done1); end
    vectors++; if (sout2 !== '0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      miscompares++; $display("FAIL reset_dut2: got state=%0h busy=%b done=%b want all 0", sout2, busy2, done2); end
    @(posedge clk); #1; rstb = 1'b1;
    @(posedge clk); #1;
    drive(1, 1'b1, 4'd12, rnd320());
    @(posedge clk); #1; drive(1, 1'b0, 4'd0, '0);
    repeat (3) @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    vectors++; if (sout1 !== '0) begin miscompares++; $display("FAIL midrun_reset_state: got %0h want 0", sout1); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL midrun_reset_busy: got %b want 0", busy1); end
    @(posedge clk); #1; rstb = 1'b1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (done1) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrun_reset_nodone: got %0d done pulses want 0", seen); end
  endtask

  task automatic test_p12_u1();
    int lat, be; logic bd; logic [319:0] res, exp;
    exp = ref_perm('0, 12);
    run(1, 4'd12, '0, lat, be, bd, res);
    vectors++; if (lat !== 12) begin miscompares++; $display("FAIL p12_u1_latency: got %0d want 12", lat); end
    vectors++; if (be !== 11) begin miscompares++; $display("FAIL p12_u1_busy_edges: got %0d want 11", be); end
    vectors++; if (bd !== 1'b0) begin miscompares++; $display("FAIL p12_u1_busy_at_done: got %b want 0", bd); end
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL p12_u1_state: got %0h want %0h", res, exp); end
  endtask

  task automatic test_u2_p6();
    int lat, be; logic bd; logic [319:0] iv, res, exp;
    iv  = {64'h80400c0600000000, 256'h0};
    exp = ref_perm(iv, 6);
    run(2, 4'd6, iv, lat, be, bd, res);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL u2_p6_latency: got %0d want 3", lat); end
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL u2_p6_state: got %0h want %0h", res, exp); end
  endtask

  task automatic test_u2_nr1();
    int lat, be; logic bd; logic [319:0] s, res, exp;
    s   = rnd320();
    exp = ref_rounds(s, 11, 1);
    run(2, 4'd1, s, lat, be, bd, res);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL u2_nr1_latency: got %0d want 1", lat); end
    vectors++; if (res !== exp) begin miscompares++; $display("FAIL u2_nr1_state: got %0h want %0h", res, exp); end
    vectors++; if (be !== 0) begin miscompares++; $display("FAIL u2_nr1_busy: got %0d busy edges want 0", be); end
  endtask

  task automatic test_random();
    int lat, be, n, en, elat; logic bd; logic [319:0] s, res, exp;
    for (int it = 0; it < 12; it++) begin
      int d;
      d  = (it % 2) + 1;
      n  = $urandom_range(0, 15);
      en = (n > 12) ? 12 : n;
      elat = (en == 0) ? 1 : (en + d - 1) / d;
      s   = rnd320();
      exp = ref_perm(s, en);
      run(d, 4'(n), s, lat, be, bd, res);
      vectors++; if (lat !== elat) begin miscompares++; $display("FAIL random_latency u%0d n=%0d: got %0d want %0d", d, n, lat, elat); end
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL random_state u%0d n=%0d: got %0h want %0h", d, n, res, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int lat, be; logic bd, dn, bz; logic [319:0] s, r1, res, e1, e2, so;
    for (int d = 1; d <= 2; d++) begin
      s  = rnd320();
      e1 = ref_perm(s, 12);
      e2 = ref_perm(e1, 8);
      run(d, 4'd12, s, lat, be, bd, res);
      r1 = res;
      vectors++; if (r1 !== e1) begin miscompares++; $display("FAIL b2b_first u%0d: got %0h want %0h", d, r1, e1); end
      drive(d, 1'b1, 4'd8, e1);
      @(posedge clk); #1;
      peek(d, dn, bz, so);
      vectors++; if (dn !== 1'b0 || bz !== 1'b1) begin
        miscompares++; $display("FAIL b2b_accept u%0d: got done=%b busy=%b want done=0 busy=1", d, dn, bz); end
      drive(d, 1'b0, 4'd0, '0);
      lat = 1;
      while (!dn && lat < 30) begin @(posedge clk); #1; lat++; peek(d, dn, bz, so); end
      vectors++; if (lat !== 8 / d) begin miscompares++; $display("FAIL b2b_latency u%0d: got %0d want %0d", d, lat, 8 / d); end
      vectors++; if (so !== e2) begin miscompares++; $display("FAIL b2b_state u%0d: got %0h want %0h", d, so, e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_start_nr15();
    int lat, extra; logic dn, bz; logic [319:0] s, so, exp;
    s   = rnd320();
    exp = ref_perm(s, 12);
    drive(1, 1'b1, 4'd15, s);
    lat = 0; dn = 1'b0;
    while (!dn && lat < 30) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) drive(1, 1'b0, 4'd0, '0);
      if (lat == 3) drive(1, 1'b1, 4'd3, rnd320());
      if (lat == 5) drive(1, 1'b0, 4'd0, '0);
      peek(1, dn, bz, so);
    end
    vectors++; if (lat !== 12) begin miscompares++; $display("FAIL busy_start_latency: got %0d want 12", lat); end
    vectors++; if (so !== exp) begin miscompares++; $display("FAIL busy_start_state: got %0h want %0h", so, exp); end
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (done1 || busy1) extra++; end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL busy_start_ignored: got %0d active cycles want 0", extra); end
    vectors++; if (sout1 !== exp) begin miscompares++; $display("FAIL hold_after_done: got %0h want %0h", sout1, exp); end
  endtask

  task automatic test_nr0();
    int lat, be; logic bd; logic [319:0] s, res;
    for (int d = 1; d <= 2; d++) begin
      s = rnd320();
      run(d, 4'd0, s, lat, be, bd, res);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL nr0_latency u%0d: got %0d want 1", d, lat); end
      vectors++; if (res !== s) begin miscompares++; $display("FAIL nr0_state u%0d: got %0h want %0h", d, res, s); end
      vectors++; if (be !== 0 || bd !== 1'b0) begin miscompares++; $display("FAIL nr0_busy u%0d: got %0d/%b want 0/0", d, be, bd); end
      @(posedge clk); #1;
      vectors++; if (d == 1 ? done1 : done2) begin miscompares++; $display("FAIL nr0_done_pulse u%0d: got 1 want 0", d); end
    end
  endtask

`ifdef ASCON_PERM_ABORT_EN
  task automatic test_abort();
    int seen, lat, be; logic bd; logic [319:0] s, exp, res;
    s   = rnd320();
    exp = ref_rounds(s, 0, 4);
    drive(1, 1'b1, 4'd12, s);
    repeat (4) begin @(posedge clk); #1; drive(1, 1'b0, 4'd0, '0); end
    abort1 = 1'b1;
    @(posedge clk); #1; abort1 = 1'b0;
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy1); end
    vectors++; if (sout1 !== exp) begin miscompares++; $display("FAIL abort_partial: got %0h want %0h", sout1, exp); end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (done1) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_nodone: got %0d want 0", seen); end
    vectors++; if (sout1 !== exp) begin miscompares++; $display("FAIL abort_hold: got %0h want %0h", sout1, exp); end
    s = rnd320();
    abort1 = 1'b1;
    run(1, 4'd1, s, lat, be, bd, res);
    abort1 = 1'b0;
    vectors++; if (lat !== 1 || res !== ref_rounds(s, 11, 1)) begin
      miscompares++; $display("FAIL abort_start_wins: got lat=%0d state=%0h want lat=1", lat, res); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_p12_u1();
    test_u2_p6();
    test_u2_nr1();
    test_random();
    test_back_to_back();
    test_busy_start_nr15();
    test_nr0();
`ifdef ASCON_PERM_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
